imem_load_ctrl: RTL
===================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter RUN_DELAY, default 2, number of idle cycles between last load word and run_flag assertion (range 0..15).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load_valid  in  1  loader word valid
- load_data  in  32  loader instruction word
- load_last  in  1  qualifies final word of program
- load_ready  out  1  controller accepts loader word
- fetch_addr  in  32  byte address from fetch stage
- run_finished  in  1  end-of-program pulse from fetch stage
- mem_we  out  1  instruction memory write enable
- mem_addr  out  ADDR_W  instruction memory word address
- mem_wdata  out  32  instruction memory write data
- mem_rdata  in  32  instruction memory read data (combinational)
- fetch_data  out  32  instruction word to fetch stage
- run_flag  out  1  fetch stage run enable
- load_count  out  ADDR_W+1  words written in current load
- overflow  out  1  sticky: program exceeded memory depth
- load_checksum  out  32  see Configuration

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, START, RUN, DONE.
REQ-005 IDLE: load_ready=1; first accepted word (load_valid&&load_ready) is written at address 0, load_count becomes 1, state -> LOAD, or -> START if load_last is set on that word.
REQ-006 LOAD: load_ready=1; each accepted word written at mem_addr=load_count[ADDR_W-1:0] in the cycle of acceptance, load_count increments at that edge.
REQ-007 Word accepted with load_last SHALL be written; state -> START, start counter loaded with RUN_DELAY.
REQ-008 START: load_ready=0, start counter decrements each cycle; when counter is 0, state -> RUN at the next edge (RUN_DELAY=0 gives RUN one cycle after last word).
REQ-009 RUN: run_flag=1, mem_we=0, mem_addr=fetch_addr[ADDR_W+1:2], fetch_data=mem_rdata, load_ready=0 (loader back-pressured).
REQ-010 RUN with run_finished=1 -> DONE at next edge; run_flag deasserts in DONE.
REQ-011 DONE: load_ready=1; accepted word behaves as in IDLE (count restarts at 0, overflow cleared, written at address 0).
REQ-012 Outside RUN: fetch_data=0, run_flag=0; run_finished ignored.
REQ-013 mem_we=1 only on accepted words in IDLE/LOAD/DONE with load_count < 2^ADDR_W; mem_wdata=load_data.
REQ-014 Accepted word with load_count == 2^ADDR_W SHALL NOT be written, SHALL set overflow, SHALL NOT increment load_count; load_last still moves state to START.
REQ-015 Outside IDLE/LOAD/DONE, mem_addr SHALL be 0 except in RUN (REQ-009).
REQ-016 load_valid deasserted in LOAD: state holds, no write, no timeout.
REQ-017 fetch_addr[1:0] ignored; halfword alignment is handled by fetch stage.

Reset
REQ-018 reset=1 SHALL immediately force IDLE, load_count=0, overflow=0, load_checksum=0, start counter=0, run_flag=0, mem_we=0, fetch_data=0, load_ready=1 after release.
REQ-019 Reset mid-LOAD or mid-RUN SHALL discard progress; memory contents are not cleared.

Configuration
REQ-020 Macro IMEM_LOAD_CHECKSUM_EN defined: load_checksum = 32-bit modulo-2^32 sum of all written words of current load, updated at the write edge, cleared when a new load starts in IDLE/DONE.
REQ-021 Macro undefined: load_checksum tied to 0, no accumulator register.

Verification
REQ-022 Load 3 words 0x00000013, 0x00100093, 0x00001111 (last on 3rd), RUN_DELAY=2 -> mem writes at 0,1,2; load_count=3; run_flag rises 3 cycles after the last-word edge.
REQ-023 In RUN, fetch_addr=0x8 with mem_rdata=0x00001111 -> mem_addr=2, fetch_data=0x00001111; load_valid=1 -> load_ready=0, no write.
REQ-024 ADDR_W=2, load 5 words, last on 5th -> 4 writes, 5th dropped, overflow=1, load_count=4, START entered.
REQ-025 run_finished pulse in RUN -> DONE, run_flag=0 next cycle; new load word 0xDEADBEEF -> written at address 0, load_count=1, overflow=0.
REQ-026 Assert reset during LOAD after 2 words -> IDLE immediately, load_count=0; next word written at address 0.
REQ-027 With IMEM_LOAD_CHECKSUM_EN, words 0xFFFFFFFF, 0x00000002 -> load_checksum=0x00000001; without macro -> 0.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
//
// Streams a program from a loader into instruction memory, waits a short
// settling delay, then hands the memory over to the fetch stage until the
// fetch stage reports the end of the program. A new load may then start.
//
// Parameters
//   ADDR_W     instruction memory word-address width (depth 2**ADDR_W words)
//   RUN_DELAY  idle cycles between the last load word and run_flag (0..15)
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   load_valid/load_data/load_last/load_ready
//                    loader word handshake; load_last marks the final word
//   fetch_addr       byte address from fetch stage (word index used in RUN)
//   run_finished     end-of-program pulse from fetch stage
//   mem_we/mem_addr/mem_wdata/mem_rdata
//                    instruction memory port (read data is combinational)
//   fetch_data       instruction word to the fetch stage (0 outside RUN)
//   run_flag         fetch stage run enable
//   load_count       words written in the current load
//   overflow         sticky: program did not fit in memory
//   load_checksum    running sum of written words
//
// Configuration
//   IMEM_LOAD_CHECKSUM_EN  when defined, load_checksum is the modulo-2**32
//                          sum of the words written in the current load;
//                          otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int RUN_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic [31:0]       fetch_addr,
    input  logic              run_finished,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       fetch_data,
    output logic              run_flag,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow,
    output logic [31:0]       load_checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);
    localparam logic [3:0]      DELAY     = 4'(RUN_DELAY);

    logic [2:0] state;
    logic [3:0] start_cnt;
    logic       fresh;
    logic       accept;
    logic       write_en;

    // Only the word-index bits of the fetch address address the memory.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    // IDLE and DONE both begin a fresh load, so their first word goes to 0
    // regardless of whatever count the previous load left behind.
    assign fresh      = (state == S_IDLE) || (state == S_DONE);
    assign load_ready = fresh || (state == S_LOAD);
    assign accept     = load_valid && load_ready;
    assign write_en   = accept && (fresh || (load_count < DEPTH));

    assign mem_we     = write_en;
    assign mem_wdata  = load_data;
    assign run_flag   = (state == S_RUN);
    assign fetch_data = run_flag ? mem_rdata : 32'd0;

    // Memory address: load position while loading, fetch word index while
    // running, and zero otherwise (also zero for the first word of a load).
    always_comb begin
        mem_addr = '0;
        case (state)
            S_LOAD:  mem_addr = load_count[ADDR_W-1:0];
            S_RUN:   mem_addr = fetch_addr[ADDR_W+1:2];
            default: mem_addr = '0;
        endcase
    end

    // Main control FSM. Once memory is full, further words are dropped and
    // flagged as overflow, but load_last still ends the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            start_cnt  <= 4'd0;
            load_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        load_count <= COUNT_ONE;
                        overflow   <= 1'b0;
                        if (load_last) begin
                            state     <= S_START;
                            start_cnt <= DELAY;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (load_count < DEPTH) begin
                            load_count <= load_count + COUNT_ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (load_last) begin
                            state     <= S_START;
                            start_cnt <= DELAY;
                        end
                    end
                end
                S_START: begin
                    if (start_cnt == 4'd0) begin
                        state <= S_RUN;
                    end else begin
                        start_cnt <= start_cnt - 4'd1;
                    end
                end
                S_RUN: begin
                    if (run_finished) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] checksum;

    // Sum of written words; the first word of a new load restarts the sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= 32'd0;
        end else if (write_en) begin
            checksum <= fresh ? load_data : (checksum + load_data);
        end
    end

    assign load_checksum = checksum;
`else
    assign load_checksum = 32'd0;
`endif

endmodule
